// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants and FSM state type for the audio conditioning path
package audio_pkg;

   localparam int MIDSCALE   = 2048;
   localparam int UNITY_GAIN = 16;
   localparam int SAT_MAX    = 32767;
   localparam int SAT_MIN    = -32768;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } cond_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchronizer with rising and falling edge pulses
module sync_edge_detect (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta   <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta   <= async_in;
         sync_q <= meta;
         prev_q <= sync_q;
      end
   end

   assign sync_out = sync_q;
   assign rise     = sync_q & ~prev_q;
   assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/audio_conditioner.sv
// rtl/audio_conditioner.sv - boxcar average, midscale removal and saturating volume ahead of the I2S transmitter
module audio_conditioner
   import audio_pkg::*;
#(
   parameter int IN_WIDTH = 12,
   parameter int LOG2_WIN = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [IN_WIDTH-1:0] sample_in,
   input  logic                sample_valid,
   input  logic [4:0]          volume,
   input  logic                lrclk,
   output logic [15:0]         audio_out,
   output logic                audio_update,
   output logic                ready
);

   localparam int WIN   = 1 << LOG2_WIN;
   localparam int SUM_W = IN_WIDTH + LOG2_WIN;
   localparam int GW    = 24;
   localparam logic [IN_WIDTH-1:0]  MID       = IN_WIDTH'(1 << (IN_WIDTH - 1));
   localparam logic [SUM_W-1:0]     SUM_CLEAR = SUM_W'(MID) << LOG2_WIN;
   localparam logic signed [GW-1:0] SAT_HI    = GW'(SAT_MAX);
   localparam logic signed [GW-1:0] SAT_LO    = GW'(SAT_MIN);

   cond_state_t          state;
   logic [LOG2_WIN-1:0]  wptr;
   logic [IN_WIDTH-1:0]  win_buf [WIN];
   logic [SUM_W-1:0]     sum;
   logic signed [15:0]   mix;

   logic                 buf_we;
   logic [IN_WIDTH-1:0]  buf_wdata;

   logic [IN_WIDTH-1:0]  avg;
   logic signed [IN_WIDTH:0] centered;
   logic signed [GW-1:0] scaled;
   logic signed [GW-1:0] product;
   logic signed [GW-1:0] shifted;
   logic signed [15:0]   mix_next;

   logic                 lr_rise;
   logic                 lr_level_unused;
   logic                 lr_fall_unused;

   sync_edge_detect u_lrclk_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (lrclk),
      .sync_out (lr_level_unused),
      .rise     (lr_rise),
      .fall     (lr_fall_unused)
   );

   always_comb begin
      buf_we    = 1'b0;
      buf_wdata = MID;
      if (state == CLEAR) begin
         buf_we = 1'b1;
      end else if (sample_valid) begin
         buf_we    = 1'b1;
         buf_wdata = sample_in;
      end
   end

   // No reset on the window storage so it maps onto distributed RAM; CLEAR rewrites every entry.
   always_ff @(posedge clk) begin
      if (reset_n && buf_we) begin
         win_buf[wptr] <= buf_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= CLEAR;
         wptr  <= '0;
         sum   <= SUM_CLEAR;
         ready <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               wptr <= wptr + LOG2_WIN'(1);
               sum  <= SUM_CLEAR;
               if (&wptr) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN: begin
               if (sample_valid) begin
                  sum  <= sum + SUM_W'(sample_in) - SUM_W'(win_buf[wptr]);
                  wptr <= wptr + LOG2_WIN'(1);
               end
            end
            default: begin
               state <= CLEAR;
               ready <= 1'b0;
            end
         endcase
      end
   end

   // Window sum never exceeds SUM_W bits, so the running update cannot wrap.
   always_comb begin
      avg      = sum[SUM_W-1:LOG2_WIN];
      centered = $signed({1'b0, avg} - {1'b0, MID});
      scaled   = GW'(centered) <<< (16 - IN_WIDTH);
      product  = scaled * $signed({{(GW - 5){1'b0}}, volume});
      shifted  = product >>> 4;
      mix_next = shifted[15:0];
      if (shifted > SAT_HI) begin
         mix_next = SAT_HI[15:0];
      end else if (shifted < SAT_LO) begin
         mix_next = SAT_LO[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mix          <= '0;
         audio_out    <= '0;
         audio_update <= 1'b0;
      end else begin
         mix          <= mix_next;
         audio_update <= lr_rise;
         if (lr_rise) begin
            audio_out <= mix;
         end
      end
   end

endmodule
